fp_sqrt_operand_loader: RTL and testbench

FP_SQRT_OPERAND_LOADER -- requirements
Module: fp_sqrt_operand_loader

---
 rtl/fp_sqrt_operand_loader.sv | 167 ++++++++++++++++
 tb/tb_fp_sqrt_operand_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_operand_loader.sv
// fp_sqrt_operand_loader
//
// Purpose: reassembles a masked floating-point square-root operand that
// arrives as XOR shares (garbler + evaluator), one CHUNK-wide slice per
// accepted cycle, LSB chunk first. Once the whole packet is in, the unmasked
// operand, rounding mode and classification flags are registered and held
// until the downstream stage takes them.
//
// Packet layout (PW = inst_sig_width + inst_exp_width + 4 bits):
//   [PW-1:PW-3] rounding mode, [PW-4] sign, then exponent, then significand.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous drop of any partial or held operand
//   g_chunk    garbler share chunk
//   e_chunk    evaluator share chunk
//   in_valid   chunk pair present
//   in_ready   loader accepts a chunk this cycle (high only while loading)
//   out_a      unmasked operand {sign, exp, sig}
//   out_rnd    unmasked rounding mode (0 when the raw mode is out of range)
//   out_flags  {rnd_err, is_nan_inf, is_zero, is_neg}
//   out_valid  operand held and valid
//   out_ready  downstream consumes operand
module fp_sqrt_operand_loader #(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8,
  parameter int CHUNK          = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [CHUNK-1:0]                       g_chunk,
  input  logic [CHUNK-1:0]                       e_chunk,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [inst_sig_width+inst_exp_width:0] out_a,
  output logic [2:0]                             out_rnd,
  output logic [3:0]                             out_flags,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int SW     = inst_sig_width;
  localparam int EW     = inst_exp_width;
  localparam int PW     = SW + EW + 4;
  localparam int NCHUNK = (PW + CHUNK - 1) / CHUNK;
  localparam int BW     = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic {
    LOAD,
    HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  packet_q, packet_d;
  logic           load_out;
  logic           accept;

  logic           sign_d;
  logic [EW-1:0]  exp_d;
  logic [SW-1:0]  sig_d;
  logic [2:0]     rnd_raw;
  logic           is_zero;
  logic           is_nan_inf;
  logic           is_neg;
  logic           rnd_err;

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  // Next-state logic. The incoming chunk is merged into packet_d so the
  // decode below sees the complete packet in the same cycle the last chunk
  // is accepted, letting the operand register load without an extra stage.
  // Flush is applied last so it wins over an accept or a transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    packet_d = packet_q;
    load_out = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
              packet_d[k*CHUNK +: CHUNK] = g_chunk ^ e_chunk;
            end
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d    = '0;
            state_d  = HOLD;
            load_out = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    if (flush) begin
      state_d  = LOAD;
      cnt_d    = '0;
      packet_d = '0;
      load_out = 1'b0;
    end
  end

  // Field extraction and classification of the assembled packet. Bits of the
  // last chunk at or above PW are simply never looked at.
  always_comb begin
    rnd_raw    = packet_d[PW-1 -: 3];
    sign_d     = packet_d[PW-4];
    exp_d      = packet_d[PW-5 -: EW];
    sig_d      = packet_d[SW-1:0];
    is_zero    = (exp_d == '0) && (sig_d == '0);
    is_nan_inf = &exp_d;
    is_neg     = sign_d && !is_zero;
    rnd_err    = (rnd_raw > 3'd5);
  end

  // Control and packet registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      packet_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      packet_q <= packet_d;
    end
  end

  // Output registers: captured together with the operand so the flags are
  // valid for the whole time it is held. A flush wipes them so a dropped
  // operand can never be observed afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a     <= '0;
      out_rnd   <= '0;
      out_flags <= '0;
    end else if (flush) begin
      out_a     <= '0;
      out_rnd   <= '0;
      out_flags <= '0;
    end else if (load_out) begin
      out_a     <= {sign_d, exp_d, sig_d};
      out_rnd   <= rnd_err ? 3'd0 : rnd_raw;
      out_flags <= {rnd_err, is_nan_inf, is_zero, is_neg};
    end
  end

endmodule

// File: tb/tb_fp_sqrt_operand_loader.sv
// tb_fp_sqrt_operand_loader
//
// Purpose: self-checking bench for fp_sqrt_operand_loader with default
// parameters (32-bit operand, 8-bit chunks, five chunks per operand).
// A reference model collects unmasked chunks in a queue and, once five are
// in, derives the operand/rounding/flags with plain arithmetic; a compare
// process checks the DUT against it every cycle. Directed operands also
// carry hand-computed literal expectations.
module tb_fp_sqrt_operand_loader;

  localparam int NCHUNK = 5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  g_chunk;
  logic [7:0]  e_chunk;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a;
  logic [2:0]  out_rnd;
  logic [3:0]  out_flags;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  bit compare_en = 0;

  bit          m_hold = 0;
  logic [7:0]  m_parts[$];
  logic [31:0] m_a = '0;
  logic [2:0]  m_rnd = '0;
  logic [3:0]  m_flags = '0;

  fp_sqrt_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .g_chunk   (g_chunk),
    .e_chunk   (e_chunk),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_rnd   (out_rnd),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unmasked chunks are queued in arrival order; five of
  // them make a 40-bit packet whose fields are classified arithmetically.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hold = 0;
        m_parts.delete();
      end else if (flush) begin
        m_hold = 0;
        m_parts.delete();
      end else if (m_hold) begin
        if (out_ready) m_hold = 0;
      end else if (in_valid) begin
        m_parts.push_back(g_chunk ^ e_chunk);
        if (m_parts.size() == NCHUNK) begin
          logic [39:0] pk;
          logic [2:0]  raw;
          bit          zero, naninf, neg, err;
          pk = '0;
          for (int i = 0; i < NCHUNK; i++) pk = pk | (40'(m_parts[i]) << (8 * i));
          m_a    = pk[31:0];
          raw    = pk[34:32];
          zero   = (m_a[30:0] == 31'd0);
          naninf = (m_a[30:23] == 8'hFF);
          neg    = m_a[31] && !zero;
          err    = (raw > 3'd5);
          m_rnd  = err ? 3'd0 : raw;
          m_flags = {err, naninf, zero, neg};
          m_hold = 1;
          m_parts.delete();
        end
      end
    end
  end

  // Compare process: handshake every cycle, operand fields while held,
  // all-zero outputs while reset is asserted.
  initial begin
    forever begin
      @(negedge clk);
      if (compare_en) begin
        checkOutput("in_ready", 40'(in_ready), 40'(!m_hold));
        checkOutput("out_valid", 40'(out_valid), 40'(m_hold));
        if (rst) begin
          checkOutput("rst_out_a", 40'(out_a), 40'd0);
          checkOutput("rst_out_rnd", 40'(out_rnd), 40'd0);
          checkOutput("rst_out_flags", 40'(out_flags), 40'd0);
        end else if (m_hold) begin
          checkOutput("model_out_a", 40'(out_a), 40'(m_a));
          checkOutput("model_out_rnd", 40'(out_rnd), 40'(m_rnd));
          checkOutput("model_out_flags", 40'(out_flags), 40'(m_flags));
        end
      end
    end
  end

  // Drives one chunk pair for exactly one cycle; only called while loading.
  task automatic sendChunk(input logic [7:0] g, input logic [7:0] e);
    in_valid = 1'b1;
    g_chunk  = g;
    e_chunk  = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Loads one operand (chunk i = byte i of the words), with optional idle
  // cycles between chunks, then checks the held result against literals.
  task automatic applyStimulus(input string name, input logic [39:0] g_word,
                               input logic [39:0] e_word, input int gap,
                               input logic [31:0] exp_a, input logic [2:0] exp_rnd,
                               input logic [3:0] exp_flags);
    for (int i = 0; i < NCHUNK; i++) begin
      sendChunk(g_word[8*i +: 8], e_word[8*i +: 8]);
      if (i != NCHUNK - 1) begin
        for (int j = 0; j < gap; j++) begin
          @(posedge clk);
          #1;
        end
      end
    end
    checkOutput({name, "_valid"}, 40'(out_valid), 40'd1);
    checkOutput({name, "_in_ready"}, 40'(in_ready), 40'd0);
    checkOutput({name, "_a"}, 40'(out_a), 40'(exp_a));
    checkOutput({name, "_rnd"}, 40'(out_rnd), 40'(exp_rnd));
    checkOutput({name, "_flags"}, 40'(out_flags), 40'(exp_flags));
  endtask

  // Stalls the held operand for a few cycles, then lets it transfer.
  task automatic releaseOperand(input int stall);
    logic [31:0] a0;
    a0 = out_a;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_a_stable", 40'(out_a), 40'(a0));
      checkOutput("stall_in_ready", 40'(in_ready), 40'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("transfer_valid_low", 40'(out_valid), 40'd0);
    checkOutput("transfer_in_ready", 40'(in_ready), 40'd1);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    g_chunk = '0; e_chunk = '0;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    compare_en = 1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 40'(in_ready), 40'd1);
    checkOutput("reset_out_valid", 40'(out_valid), 40'd0);
    checkOutput("reset_out_a", 40'(out_a), 40'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed operands");
    applyStimulus("zero_shares", 40'h0, 40'h00_40_80_00_00, 0, 32'h40800000, 3'd0, 4'b0000);
    releaseOperand(0);
    applyStimulus("masked", 40'hFF_FF_FF_FF_FF, 40'hF8_BF_7F_FF_FF, 0, 32'h40800000, 3'd0, 4'b1000);
    releaseOperand(0);
    applyStimulus("negative", 40'h0, 40'h01_BF_80_00_00, 0, 32'hBF800000, 3'd1, 4'b0001);
    releaseOperand(0);
    applyStimulus("neg_zero", 40'h0, 40'h00_80_00_00_00, 0, 32'h80000000, 3'd0, 4'b0010);
    releaseOperand(0);
    applyStimulus("nan_high_bits", 40'h0, 40'hF9_7F_C0_00_00, 0, 32'h7FC00000, 3'd1, 4'b0100);
    releaseOperand(3);
    applyStimulus("rnd5", 40'h0, 40'h05_3F_80_00_00, 0, 32'h3F800000, 3'd5, 4'b0000);
    releaseOperand(0);
    applyStimulus("rnd6", 40'h0, 40'h06_3F_80_00_00, 0, 32'h3F800000, 3'd0, 4'b1000);
    releaseOperand(0);
    applyStimulus("gaps", 40'h0, 40'h00_40_80_00_00, 2, 32'h40800000, 3'd0, 4'b0000);
    releaseOperand(3);

    $display("[TB] streaming with out_ready held high");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    g_chunk   = 8'h00;
    pulses    = 0;
    for (int c = 0; c < 12; c++) begin
      e_chunk = 8'(c + 8'h10);
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("stream_operands", 40'(pulses), 40'd2);

    $display("[TB] flush mid-load with simultaneous chunk");
    sendChunk(8'h00, 8'hAA);
    sendChunk(8'h00, 8'hBB);
    flush = 1'b1; in_valid = 1'b1; g_chunk = 8'h00; e_chunk = 8'hCC;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    applyStimulus("after_flush", 40'h0, 40'h00_3F_80_00_00, 0, 32'h3F800000, 3'd0, 4'b0000);

    $display("[TB] flush in hold with simultaneous transfer");
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    checkOutput("flush_hold_valid", 40'(out_valid), 40'd0);
    checkOutput("flush_hold_in_ready", 40'(in_ready), 40'd1);
    applyStimulus("post_hold_flush", 40'h0, 40'h02_C0_00_00_00, 0, 32'hC0000000, 3'd2, 4'b0001);
    releaseOperand(0);

    $display("[TB] asynchronous reset mid-load and in hold");
    sendChunk(8'h00, 8'h11);
    sendChunk(8'h00, 8'h22);
    sendChunk(8'h00, 8'h33);
    rst = 1'b1;
    #2;
    checkOutput("async_rst_in_ready", 40'(in_ready), 40'd1);
    checkOutput("async_rst_valid", 40'(out_valid), 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("fresh_after_rst", 40'h0, 40'h00_3F_80_00_00, 0, 32'h3F800000, 3'd0, 4'b0000);
    rst = 1'b1;
    #2;
    checkOutput("hold_rst_valid", 40'(out_valid), 40'd0);
    checkOutput("hold_rst_a", 40'(out_a), 40'd0);
    checkOutput("hold_rst_flags", 40'(out_flags), 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("after_hold_rst", 40'h0, 40'h03_41_20_00_00, 0, 32'h41200000, 3'd3, 4'b0000);
    releaseOperand(1);

    @(posedge clk);
    #1;
    compare_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
